// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M divide sequencer.
package div_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic [XLEN_DEF-1:0] OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [XLEN_DEF-1:0] OVF_DIVISOR  = 32'hFFFF_FFFF;

  // Codes outside the M-extension divide group fall back to DIVU.
  function automatic logic [2:0] f3_norm(input logic [2:0] f3);
    logic [2:0] f_s;
    if (f3[2]) begin
      f_s = f3;
    end else begin
      f_s = F3_DIVU;
    end
    return f_s;
  endfunction

endpackage

// File: rtl/div_complementer.sv
// Conditional two's complementer: passes the operand through or negates it.
module div_complementer #(
  parameter int W = 32
) (
  input  logic         sel_i,
  input  logic [W-1:0] a_i,
  output logic [W-1:0] y_o
);

  assign y_o = sel_i ? (~a_i + {{(W-1){1'b0}}, 1'b1}) : a_i;

endmodule

// File: rtl/div_core_step.sv
// One combinational restoring-divide iteration (shift in quotient MSB, trial subtract).
module div_core_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] q_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] q_o
);

  logic [XLEN:0] shifted_s;
  logic [XLEN:0] diff_s;

  // The shifted remainder keeps one extra bit so divisors with MSB set compare correctly.
  always_comb begin
    shifted_s = {rem_i, q_i[XLEN-1]};
    diff_s    = shifted_s - {1'b0, divisor_i};
    if (shifted_s >= {1'b0, divisor_i}) begin
      rem_o = diff_s[XLEN-1:0];
      q_o   = {q_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = shifted_s[XLEN-1:0];
      q_o   = {q_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU controller for the EX stage.
// Optional DIV_EARLY_OUT_EN skips the iterations when |dividend| < |divisor|.
module div_sequencer
  import div_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] DIVIDEND,
  input  logic [XLEN-1:0] DIVISOR,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            STALL,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   q_q, q_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              op_rem_q, op_rem_d;
  logic              op_sgn_q, op_sgn_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;

  logic [2:0]        f3_in_s;
  logic              div0_s;
  logic              ovf_s;
  logic [XLEN-1:0]   a_mag_s;
  logic [XLEN-1:0]   b_mag_s;
  logic [XLEN-1:0]   q_fix_s;
  logic [XLEN-1:0]   r_fix_s;
  logic [XLEN-1:0]   step_rem_s;
  logic [XLEN-1:0]   step_q_s;

  assign f3_in_s = f3_norm(FUNCT3);
  assign div0_s  = (DIVISOR == {XLEN{1'b0}});
  assign ovf_s   = ~f3_in_s[0] && (DIVIDEND == OVF_DIVIDEND) && (DIVISOR == OVF_DIVISOR);

  div_complementer #(.W(XLEN)) u_cmp_a (
    .sel_i (op_sgn_q & a_q[XLEN-1]),
    .a_i   (a_q),
    .y_o   (a_mag_s)
  );

  div_complementer #(.W(XLEN)) u_cmp_b (
    .sel_i (op_sgn_q & b_q[XLEN-1]),
    .a_i   (b_q),
    .y_o   (b_mag_s)
  );

  div_complementer #(.W(XLEN)) u_cmp_q (
    .sel_i (qneg_q),
    .a_i   (q_q),
    .y_o   (q_fix_s)
  );

  div_complementer #(.W(XLEN)) u_cmp_r (
    .sel_i (rneg_q),
    .a_i   (rem_q),
    .y_o   (r_fix_s)
  );

  div_core_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .q_i       (q_q),
    .divisor_i (b_q),
    .rem_o     (step_rem_s),
    .q_o       (step_q_s)
  );

  // Next-state and datapath update; b_q holds the raw divisor until PREP, its magnitude after.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    q_d      = q_q;
    rem_d    = rem_q;
    result_d = result_q;
    op_rem_d = op_rem_q;
    op_sgn_d = op_sgn_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    case (state_q)
      S_IDLE: begin
        if (FLUSH) begin
          state_d = S_IDLE;
        end else if (START) begin
          a_d      = DIVIDEND;
          b_d      = DIVISOR;
          op_rem_d = f3_in_s[1];
          op_sgn_d = ~f3_in_s[0];
          if (div0_s) begin
            result_d = f3_in_s[1] ? DIVIDEND : {XLEN{1'b1}};
            state_d  = S_DONE;
          end else if (ovf_s) begin
            result_d = f3_in_s[1] ? {XLEN{1'b0}} : OVF_DIVIDEND;
            state_d  = S_DONE;
          end else begin
            state_d  = S_PREP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        if (FLUSH) begin
          state_d = S_IDLE;
        end else begin
          qneg_d = op_sgn_q & (a_q[XLEN-1] ^ b_q[XLEN-1]);
          rneg_d = op_sgn_q & a_q[XLEN-1];
          b_d    = b_mag_s;
          cnt_d  = {CNT_W{1'b0}};
`ifdef DIV_EARLY_OUT_EN
          if (a_mag_s < b_mag_s) begin
            q_d     = {XLEN{1'b0}};
            rem_d   = a_mag_s;
            state_d = S_FIX;
          end else begin
            q_d     = a_mag_s;
            rem_d   = {XLEN{1'b0}};
            state_d = S_ITER;
          end
`else
          q_d     = a_mag_s;
          rem_d   = {XLEN{1'b0}};
          state_d = S_ITER;
`endif
        end
      end
      S_ITER: begin
        if (FLUSH) begin
          state_d = S_IDLE;
        end else begin
          rem_d = step_rem_s;
          q_d   = step_q_s;
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = S_FIX;
          end else begin
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state_d = S_ITER;
          end
        end
      end
      S_FIX: begin
        if (FLUSH) begin
          state_d = S_IDLE;
        end else begin
          result_d = op_rem_q ? r_fix_s : q_fix_s;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      a_q      <= {XLEN{1'b0}};
      b_q      <= {XLEN{1'b0}};
      q_q      <= {XLEN{1'b0}};
      rem_q    <= {XLEN{1'b0}};
      result_q <= {XLEN{1'b0}};
      op_rem_q <= 1'b0;
      op_sgn_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      q_q      <= q_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      op_rem_q <= op_rem_d;
      op_sgn_q <= op_sgn_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
    end
  end

  assign BUSY   = (state_q != S_IDLE);
  assign DONE   = (state_q == S_DONE);
  assign STALL  = BUSY | (START & (state_q == S_IDLE));
  assign RESULT = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Randomized self-checking bench for div_sequencer against an arithmetic reference model.
module tb_div_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [2:0]  FUNCT3;
  logic [31:0] DIVIDEND;
  logic [31:0] DIVISOR;
  logic        FLUSH;
  logic        BUSY;
  logic        STALL;
  logic        DONE;
  logic [31:0] RESULT;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] last_res = 32'd0;

  always #5 CLK = ~CLK;

  div_sequencer dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .START    (START),
    .FUNCT3   (FUNCT3),
    .DIVIDEND (DIVIDEND),
    .DIVISOR  (DIVISOR),
    .FLUSH    (FLUSH),
    .BUSY     (BUSY),
    .STALL    (STALL),
    .DONE     (DONE),
    .RESULT   (RESULT)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_rem_op(input logic [2:0] f3);
    return (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic bit is_sgn_op(input logic [2:0] f3);
    return (f3 == 3'b100) || (f3 == 3'b110);
  endfunction

  // RISC-V M-extension divide semantics, computed with plain arithmetic.
  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [2:0] f;
    f = (f3 >= 3'b100) ? f3 : 3'b101;
    if (b == 32'd0) return is_rem_op(f) ? a : 32'hFFFF_FFFF;
    if (is_sgn_op(f)) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem_op(f) ? 32'd0 : 32'h8000_0000;
      return is_rem_op(f) ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return is_rem_op(f) ? (a % b) : (a / b);
  endfunction

  // Clock edges from the accepting edge up to the one that raises DONE.
  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [2:0]  f;
    logic [31:0] ma;
    logic [31:0] mb;
    f = (f3 >= 3'b100) ? f3 : 3'b101;
    if (b == 32'd0) return 1;
    if (is_sgn_op(f) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    ma = (is_sgn_op(f) && $signed(a) < 0) ? -a : a;
    mb = (is_sgn_op(f) && $signed(b) < 0) ? -b : b;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 3;
`endif
    if (ma == mb) return 35;
    return 35;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int          exp_lat;
    int          n;
    int          busy_n;
    exp     = ref_div(f3, a, b);
    exp_lat = ref_lat(f3, a, b);
    FUNCT3   = f3;
    DIVIDEND = a;
    DIVISOR  = b;
    START    = 1'b1;
    @(posedge CLK); #1;
    START    = 1'b0;
    DIVIDEND = $urandom;
    DIVISOR  = $urandom;
    FUNCT3   = 3'($urandom);
    n        = 1;
    busy_n   = 0;
    while (!DONE && n < 200) begin
      if (BUSY) busy_n++;
      @(posedge CLK); #1;
      n++;
    end
    if (BUSY) busy_n++;
    chk({tag, " done"}, {31'd0, DONE}, 32'd1);
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    chk({tag, " busy cycles"}, 32'(busy_n), 32'(exp_lat));
    chk({tag, " result"}, RESULT, exp);
    START    = 1'b1;
    FUNCT3   = 3'b101;
    DIVIDEND = 32'd9;
    DIVISOR  = 32'd3;
    @(posedge CLK); #1;
    START    = 1'b0;
    chk({tag, " idle after done"}, {30'd0, BUSY, DONE}, 32'd0);
    chk({tag, " result held"}, RESULT, exp);
    last_res = exp;
  endtask

  initial begin
    int dones;
    int sel;
    logic [31:0] ra;
    logic [31:0] rb;
    RESET    = 1'b0;
    START    = 1'b0;
    FLUSH    = 1'b0;
    FUNCT3   = 3'b101;
    DIVIDEND = 32'd0;
    DIVISOR  = 32'd0;
    #12;
    chk("reset outputs", {29'd0, BUSY, DONE, STALL}, 32'd0);
    chk("reset result", RESULT, 32'd0);
    @(negedge CLK) RESET = 1'b1;
    @(posedge CLK); #1;

    run_op("divu 100/7", 3'b101, 32'd100, 32'd7);
    run_op("rem -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2);
    run_op("div -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2);
    run_op("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu ovf ops", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu 5/0", 3'b101, 32'd5, 32'd0);
    run_op("remu 5/0", 3'b111, 32'd5, 32'd0);
    run_op("div -9/0", 3'b100, 32'hFFFF_FFF7, 32'd0);
    run_op("divu 3/10", 3'b101, 32'd3, 32'd10);
    run_op("remu 3/10", 3'b111, 32'd3, 32'd10);
    run_op("remu big", 3'b111, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    run_op("div minneg/1", 3'b100, 32'h8000_0000, 32'd1);
    run_op("f3 000 as divu", 3'b000, 32'hFFFF_FFF9, 32'd2);

    // flush during the iteration phase
    FUNCT3 = 3'b101; DIVIDEND = 32'd1000; DIVISOR = 32'd3; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK); #1;
    repeat (10) @(posedge CLK);
    #1 FLUSH = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    chk("flush busy", {31'd0, BUSY}, 32'd0);
    chk("flush result kept", RESULT, last_res);
    dones = 0;
    repeat (40) begin
      if (DONE) dones++;
      @(posedge CLK); #1;
    end
    chk("flush no done", 32'(dones), 32'd0);
    run_op("after flush", 3'b100, 32'hFFFF_FC18, 32'd7);

    // flush wins over start in idle
    FUNCT3 = 3'b101; DIVIDEND = 32'd50; DIVISOR = 32'd5; START = 1'b1; FLUSH = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0; FLUSH = 1'b0;
    chk("flush beats start", {31'd0, BUSY}, 32'd0);

    // starts while busy are ignored
    FUNCT3 = 3'b101; DIVIDEND = 32'd77; DIVISOR = 32'd5; START = 1'b1;
    @(posedge CLK); #1;
    chk("stall while busy", {31'd0, STALL}, 32'd1);
    dones = 0;
    repeat (60) begin
      START    = (BUSY && !DONE) ? 1'b1 : 1'b0;
      DIVIDEND = $urandom;
      DIVISOR  = $urandom_range(1, 9);
      if (DONE) begin
        dones++;
        chk("busy-start result", RESULT, 32'd15);
      end
      @(posedge CLK); #1;
    end
    START = 1'b0;
    chk("busy-start one done", 32'(dones), 32'd1);
    last_res = 32'd15;

    // asynchronous reset in the middle of the iterations
    FUNCT3 = 3'b111; DIVIDEND = 32'd12345; DIVISOR = 32'd77; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (12) @(posedge CLK);
    #3 RESET = 1'b0;
    #1;
    chk("async reset flags", {29'd0, BUSY, DONE, STALL}, 32'd0);
    chk("async reset result", RESULT, 32'd0);
    @(negedge CLK) RESET = 1'b1;
    @(posedge CLK); #1;
    last_res = 32'd0;

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 5);
      ra  = $urandom;
      rb  = $urandom;
      case (sel)
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 15);
        3: begin ra = $urandom_range(0, 100); rb = rb | 32'h0001_0000; end
        4: rb = -($urandom_range(1, 20));
        default: ;
      endcase
      run_op("random", 3'($urandom_range(0, 7)), ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
